// File: rtl/block_xfer_seq.sv
// Multi-cycle LDM/STM sequencer: walks the register list lowest-first, issues one
// memory beat per listed register, then spends one cycle on the optional base writeback.
module block_xfer_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        up,
    input  logic        pre,
    input  logic        writeback,
    input  logic        user_bank,
    input  logic [15:0] reg_list,
    input  logic [3:0]  base_reg,
    input  logic [31:0] base_val,
    input  logic [4:0]  cur_mode,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [4:0]  rf_mode,
    output logic [3:0]  rf_rm,
    output logic [3:0]  rf_rd,
    output logic        rf_write,
    output logic        rf_wsel,
    output logic [31:0] wb_addr,
    output logic        pc_loaded
);

    typedef enum logic [1:0] {IDLE, XFER, WB} state_t;

    state_t      state_q;
    logic [15:0] list_q;
    logic [31:0] addr_q;
    logic [31:0] wb_q;
    logic [3:0]  rn_q;
    logic [4:0]  mode_q;
    logic        load_q;
    logic        wb_en_q;
    logic        user_q;
    logic        pc_q;
    logic        base_hit_q;

    logic [4:0]  n_cnt;
    logic [31:0] four_n;
    logic [31:0] start_addr;
    logic [3:0]  cur_idx;
    logic [15:0] list_d;

    always_comb begin
        n_cnt = '0;
        for (int i = 0; i < 16; i++) begin
            n_cnt = n_cnt + {4'b0, reg_list[i]};
        end
    end

    assign four_n = {25'b0, n_cnt, 2'b00};

    // Beats always run at ascending addresses, so a descending transfer starts at its lowest word.
    always_comb begin
        if (up) begin
            start_addr = pre ? base_val + 32'd4 : base_val;
        end else begin
            start_addr = pre ? base_val - four_n : base_val - four_n + 32'd4;
        end
    end

    always_comb begin
        cur_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (list_q[i]) begin
                cur_idx = 4'(i);
            end
        end
    end

    // Clearing the lowest set bit retires the beat that just completed.
    assign list_d = list_q & (list_q - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            list_q     <= '0;
            addr_q     <= '0;
            wb_q       <= '0;
            rn_q       <= '0;
            mode_q     <= '0;
            load_q     <= 1'b0;
            wb_en_q    <= 1'b0;
            user_q     <= 1'b0;
            pc_q       <= 1'b0;
            base_hit_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        list_q     <= reg_list;
                        addr_q     <= start_addr;
                        wb_q       <= up ? base_val + four_n : base_val - four_n;
                        rn_q       <= base_reg;
                        mode_q     <= cur_mode;
                        load_q     <= is_load;
                        wb_en_q    <= writeback;
                        user_q     <= user_bank && (!is_load || !reg_list[15]);
                        pc_q       <= is_load && reg_list[15];
                        base_hit_q <= reg_list[base_reg];
                        state_q    <= (n_cnt == 5'd0) ? WB : XFER;
                    end
                end
                XFER: begin
                    if (mem_ready) begin
                        list_q <= list_d;
                        addr_q <= addr_q + 32'd4;
                        if (list_d == 16'd0) begin
                            state_q <= WB;
                        end
                    end
                end
                WB:      state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        rf_mode   = cur_mode;
        rf_rm     = '0;
        rf_rd     = '0;
        rf_write  = 1'b0;
        rf_wsel   = 1'b0;
        wb_addr   = '0;
        pc_loaded = 1'b0;
        case (state_q)
            XFER: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_we   = !load_q;
                mem_addr = {addr_q[31:2], 2'b00};
                rf_mode  = user_q ? 5'b10000 : mode_q;
                rf_rm    = cur_idx;
                rf_rd    = cur_idx;
                rf_write = load_q && mem_ready;
                wb_addr  = wb_q;
            end
            WB: begin
                busy      = 1'b1;
                done      = 1'b1;
                rf_mode   = mode_q;
                rf_rd     = rn_q;
                rf_write  = wb_en_q && !(load_q && base_hit_q);
                rf_wsel   = 1'b1;
                wb_addr   = wb_q;
                pc_loaded = pc_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_block_xfer_seq.sv
// Bench for block_xfer_seq: table of transfers checked beat-by-beat against a scoreboard,
// plus hand-written reset sequences.
module tb_block_xfer_seq;

    logic        clk = 1'b0;
    logic        rst, start, is_load, up, pre, writeback, user_bank, mem_ready;
    logic [15:0] reg_list;
    logic [3:0]  base_reg;
    logic [31:0] base_val;
    logic [4:0]  cur_mode;
    logic        busy, done, mem_req, mem_we, rf_write, rf_wsel, pc_loaded;
    logic [31:0] mem_addr, wb_addr;
    logic [4:0]  rf_mode;
    logic [3:0]  rf_rm, rf_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    block_xfer_seq dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .up(up), .pre(pre),
        .writeback(writeback), .user_bank(user_bank), .reg_list(reg_list),
        .base_reg(base_reg), .base_val(base_val), .cur_mode(cur_mode),
        .mem_ready(mem_ready), .busy(busy), .done(done), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .rf_mode(rf_mode), .rf_rm(rf_rm),
        .rf_rd(rf_rd), .rf_write(rf_write), .rf_wsel(rf_wsel), .wb_addr(wb_addr),
        .pc_loaded(pc_loaded)
    );

    typedef struct {
        logic        ld, up, pre, w, s;
        logic [15:0] list;
        logic [3:0]  rn;
        logic [31:0] base;
        logic [4:0]  mode;
        int          stall_beat;
        int          stall_n;
        logic        hold;
    } tc_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  idx;
    } beat_t;

    beat_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    task automatic run_case(input tc_t tc, input int id);
        int          n;
        int          exp_done;
        int          beat;
        int          stall_left;
        bit          seen_done;
        logic [31:0] a;
        logic [31:0] wbe;
        logic [4:0]  me;
        beat_t       b;

        n = 0;
        for (int i = 0; i < 16; i++) n += int'(tc.list[i]);
        if (tc.up) a = tc.pre ? tc.base + 32'd4 : tc.base;
        else       a = tc.base - 32'(4 * n) + (tc.pre ? 32'd0 : 32'd4);
        wbe = tc.up ? tc.base + 32'(4 * n) : tc.base - 32'(4 * n);
        me  = (tc.s && (!tc.ld || !tc.list[15])) ? 5'b10000 : tc.mode;
        sb.delete();
        for (int i = 0; i < 16; i++) begin
            if (tc.list[i]) begin
                b.addr = a & 32'hFFFF_FFFC;
                b.idx  = 4'(i);
                sb.push_back(b);
                a = a + 32'd4;
            end
        end
        exp_done = n + 1 + ((tc.stall_beat >= 0 && tc.stall_beat < n) ? tc.stall_n : 0);

        @(negedge clk);
        is_load = tc.ld; up = tc.up; pre = tc.pre; writeback = tc.w; user_bank = tc.s;
        reg_list = tc.list; base_reg = tc.rn; base_val = tc.base; cur_mode = tc.mode;
        start = 1'b1; mem_ready = 1'b1;

        seen_done = 0; beat = 0; stall_left = tc.stall_n;
        for (int k = 1; k <= 60 && !seen_done; k++) begin
            @(posedge clk);
            #1;
            start = tc.hold;
            // Scramble the launch inputs so any use of unlatched values shows up.
            is_load = ~tc.ld; up = ~tc.up; pre = ~tc.pre; writeback = ~tc.w;
            user_bank = ~tc.s; reg_list = ~tc.list; base_reg = ~tc.rn; base_val = ~tc.base;
            if (beat == tc.stall_beat && stall_left > 0) begin
                mem_ready = 1'b0;
                stall_left--;
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clk);
            chk("busy_active", busy, 1);
            if (mem_req) begin
                if (sb.size() == 0) begin
                    fail_now("extra_beat");
                end else begin
                    chk("beat_addr", mem_addr, sb[0].addr);
                    chk("beat_rm", rf_rm, sb[0].idx);
                    chk("beat_rd", rf_rd, sb[0].idx);
                    chk("beat_we", mem_we, !tc.ld);
                    chk("beat_rf_write", rf_write, tc.ld && mem_ready);
                    chk("beat_mode", rf_mode, me);
                    chk("beat_done", done, 0);
                    if (mem_ready) begin
                        $display("case %0d beat %0d addr=%h idx=%0d mode=%b", id, beat, mem_addr, rf_rm, rf_mode);
                        void'(sb.pop_front());
                        beat++;
                    end
                end
            end else if (done) begin
                seen_done = 1;
                chk("done_cycle", k, exp_done);
                chk("wb_addr", wb_addr, wbe);
                chk("wb_rd", rf_rd, tc.rn);
                chk("wb_write", rf_write, tc.w && !(tc.ld && tc.list[tc.rn]));
                chk("wb_wsel", rf_wsel, 1);
                chk("pc_loaded", pc_loaded, tc.ld && tc.list[15]);
                chk("wb_mode", rf_mode, tc.mode);
                chk("beats_left", sb.size(), 0);
            end else begin
                fail_now("no_req_no_done");
            end
        end
        if (!seen_done) fail_now("done_timeout");

        @(posedge clk);
        #1;
        start = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_req", mem_req, 0);
        chk("idle_wb_addr", wb_addr, 0);
        chk("idle_mode", rf_mode, tc.mode);
        $display("case %0d list=%h n=%0d base=%h wb=%h done_cycle=%0d", id, tc.list, n, tc.base, wbe, exp_done);
    endtask

    tc_t tcs[10];

    initial begin
        int done_cnt;

        //            ld    up    pre   w     s     list      rn    base          mode      sb  sn hold
        tcs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h000A, 4'd0,  32'h0000_1000, 5'b10011, -1, 0, 1'b0};
        tcs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0070, 4'd1,  32'h0000_2000, 5'b10011, -1, 0, 1'b0};
        tcs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0070, 4'd1,  32'h0000_2000, 5'b10011,  1, 3, 1'b0};
        tcs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0006, 4'd2,  32'h0000_3000, 5'b10011, -1, 0, 1'b0};
        tcs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h8000, 4'd3,  32'h0000_4000, 5'b10011, -1, 0, 1'b0};
        tcs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0100, 4'd4,  32'h0000_5000, 5'b10001, -1, 0, 1'b0};
        tcs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd5,  32'h0000_6003, 5'b10011, -1, 0, 1'b0};
        tcs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 4'd13, 32'h0000_7000, 5'b10010, 15, 2, 1'b1};
        tcs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00F0, 4'd9,  32'h0000_000B, 5'b11111,  0, 1, 1'b1};
        tcs[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0401, 4'd10, 32'h0000_9000, 5'b10111, -1, 0, 1'b0};

        rst = 1'b1; start = 1'b0; is_load = 1'b0; up = 1'b0; pre = 1'b0; writeback = 1'b0;
        user_bank = 1'b0; reg_list = '0; base_reg = '0; base_val = '0; cur_mode = 5'b10011;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rf_write", rf_write, 0);
        chk("rst_wsel", rf_wsel, 0);
        chk("rst_rm", rf_rm, 0);
        chk("rst_rd", rf_rd, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_pc", pc_loaded, 0);
        chk("rst_mode", rf_mode, 5'b10011);
        $display("reset state checked");
        rst = 1'b0;

        for (int t = 0; t < 10; t++) run_case(tcs[t], t);

        // Reset in the middle of a load: the beat is abandoned and no writeback follows.
        @(negedge clk);
        is_load = 1'b1; up = 1'b1; pre = 1'b0; writeback = 1'b1; user_bank = 1'b0;
        reg_list = 16'h00F0; base_reg = 4'd1; base_val = 32'h0000_0100; cur_mode = 5'b10011;
        start = 1'b1; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_req", mem_req, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rf_write", rf_write, 0);
        chk("midrst_addr", mem_addr, 0);
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        chk("midrst_no_wb", done_cnt, 0);
        $display("mid-transfer reset checked");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
